// File: rtl/seq_gen_pkg.sv
//------------------------------------------------------------------------------
// Module   : seq_gen_pkg
// Purpose  : Shared definitions for the serial pattern generator: FSM state
//            encoding and default widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_gen_pkg;

  localparam int unsigned c_DEF_PAT_W = 4;
  localparam int unsigned c_DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_piso_shift.sv
//------------------------------------------------------------------------------
// Module   : seq_piso_shift
// Purpose  : Parallel-load, MSB-first shift register. Zeros are shifted in at
//            the LSB, so after WIDTH shifts the register is empty and the
//            serial output rests at 0.
// Ports    : clk      - rising-edge clock
//            rst      - asynchronous active-high clear
//            load_i   - load data_i (has priority over shift_i)
//            shift_i  - shift one position towards the MSB
//            data_i   - parallel load value
//            sout_o   - serial output (current MSB)
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_piso_shift #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             sout_o
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  always_comb begin
    shreg_d = shreg_q;
    if (load_i) begin
      shreg_d = data_i;
    end else if (shift_i) begin
      shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign sout_o = shreg_q[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
//------------------------------------------------------------------------------
// Module   : seq_pattern_gen
// Purpose  : Serial pattern transmitter. Sends a latched PAT_W-bit pattern
//            MSB-first, repeated repeat_cnt times with gap_len idle cycles
//            between copies, then pulses done.
// Ports    : clk        - rising-edge clock
//            rst        - asynchronous active-high reset
//            start      - request pulse, sampled only in IDLE
//            abort      - synchronous cancel of the current transfer
//            pattern    - pattern to send (MSB first)
//            repeat_cnt - number of copies (0 = none, done only)
//            gap_len    - idle cycles between copies (0 = back-to-back)
//            x          - registered serial data
//            valid      - x carries a pattern bit
//            busy       - transfer in progress (SEND or GAP)
//            done       - one-cycle completion pulse
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int unsigned PAT_W = c_DEF_PAT_W,
  parameter int unsigned CNT_W = c_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [CNT_W-1:0] gap_len,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned     c_BIT_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]   c_ONE      = CNT_W'(1);

  state_e             state_q, state_d;
  logic [c_BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]   copies_q, copies_d;
  logic [CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   gap_len_q, gap_len_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic               done_q, done_d;
  logic               valid_q, busy_q;

  logic               sr_load;
  logic               sr_shift;
  logic [PAT_W-1:0]   sr_data;
  logic               sr_out;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    copies_d  = copies_q;
    gap_cnt_d = gap_cnt_q;
    gap_len_d = gap_len_q;
    pat_d     = pat_q;
    done_d    = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_data   = pat_q;

    unique case (state_q)
      IDLE: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          if (repeat_cnt != '0) begin
            pat_d     = pattern;
            copies_d  = repeat_cnt;
            gap_len_d = gap_len;
            bit_cnt_d = '0;
            sr_load   = 1'b1;
            sr_data   = pattern;
            state_d   = SEND;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      SEND: begin
        if (abort) begin
          // Loading zero empties the shifter so x drops with valid.
          sr_load   = 1'b1;
          sr_data   = '0;
          bit_cnt_d = '0;
          copies_d  = '0;
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else if (bit_cnt_q == c_LAST_BIT) begin
          bit_cnt_d = '0;
          copies_d  = copies_q - c_ONE;
          if (copies_q == c_ONE) begin
            // Final shift leaves the register at zero.
            sr_shift = 1'b1;
            done_d   = 1'b1;
            state_d  = IDLE;
          end else if (gap_len_q != '0) begin
            sr_shift  = 1'b1;
            gap_cnt_d = gap_len_q;
            state_d   = GAP;
          end else begin
            // Back-to-back: reload in place, no bubble.
            sr_load = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          sr_shift  = 1'b1;
        end
      end

      GAP: begin
        if (abort) begin
          copies_d  = '0;
          gap_cnt_d = '0;
          state_d   = IDLE;
        end else if (gap_cnt_q == c_ONE) begin
          gap_cnt_d = '0;
          sr_load   = 1'b1;
          state_d   = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - c_ONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      copies_q  <= '0;
      gap_cnt_q <= '0;
      gap_len_q <= '0;
      pat_q     <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      copies_q  <= copies_d;
      gap_cnt_q <= gap_cnt_d;
      gap_len_q <= gap_len_d;
      pat_q     <= pat_d;
      done_q    <= done_d;
      valid_q   <= (state_d == SEND);
      busy_q    <= (state_d != IDLE);
    end
  end

  seq_piso_shift #(
    .WIDTH (PAT_W)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (sr_data),
    .sout_o  (sr_out)
  );

  assign x     = sr_out;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

`default_nettype wire
